// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
//  Bundles the IO-bus write side and the display pin side of the 7-segment
//  scan controller so the controller can be wired with a single port.
//
//  Signals
//   WR_EN       1   one-cycle write strobe for the display address
//   WR_DATA     28  raw segment frame, [6:0]=digit0 (rightmost) .. [27:21]=digit3
//   BRIGHT      2   brightness level, 0=25% .. 3=100% of the lit window
//   AN          4   anode enables, active-low
//   SEG_N       7   segment drive, active-low
//   PENDING     1   shadow frame written but not yet displayed
//   FRAME_TICK  1   one-cycle pulse after every frame boundary
//
//  Modports
//   master : the IO write decode / bench side (drives writes, observes pins)
//   slave  : the scan controller
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if;
    logic        WR_EN;
    logic [27:0] WR_DATA;
    logic [1:0]  BRIGHT;
    logic [3:0]  AN;
    logic [6:0]  SEG_N;
    logic        PENDING;
    logic        FRAME_TICK;

    modport master (
        output WR_EN,
        output WR_DATA,
        output BRIGHT,
        input  AN,
        input  SEG_N,
        input  PENDING,
        input  FRAME_TICK
    );

    modport slave (
        input  WR_EN,
        input  WR_DATA,
        input  BRIGHT,
        output AN,
        output SEG_N,
        output PENDING,
        output FRAME_TICK
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//  Scan controller for a 4-digit multiplexed 7-segment display.
//  IO writes land in a shadow frame; the shadow is copied to the displayed
//  (front) frame only on a frame boundary so a frame never tears. Each digit
//  is preceded by an all-anodes-off blanking gap to suppress ghosting, and the
//  lit window is trimmed in quarters for 4-level brightness.
//
//  Ports
//   CLK    in   system clock
//   RESET  in   asynchronous, active-high
//   bus    slave modport of seg_scan_ctrl_if
//            WR_EN/WR_DATA/BRIGHT in, AN/SEG_N/PENDING/FRAME_TICK out
//
//  Parameters
//   ACTIVE_CYCLES  lit window per digit in CLK cycles (power of two, >= 4)
//   BLANK_CYCLES   blanking gap before each digit in CLK cycles (>= 1)
//
//  FSM states
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_BLANK  | all anodes off, counting the gap before the current digit
//   ST_ACTIVE | current digit window, lit for the first bright_q+1 quarters
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int ACTIVE_CYCLES = 16384,
    parameter int BLANK_CYCLES  = 64
) (
    input  logic            CLK,
    input  logic            RESET,
    seg_scan_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (ACTIVE_CYCLES > BLANK_CYCLES) ? ACTIVE_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    // Width of the active-window count; its top two bits give the quarter.
    localparam int AW      = $clog2(ACTIVE_CYCLES);

    localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ACTIVE_LAST = CW'(ACTIVE_CYCLES - 1);

    typedef enum logic {
        ST_BLANK  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t      state_q,      state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [1:0]  digit_q,      digit_d;
    logic [1:0]  bright_q,     bright_d;
    logic [27:0] shadow_q,     shadow_d;
    logic [27:0] front_q,      front_d;
    logic        pending_q,    pending_d;
    logic        frame_tick_q, frame_tick_d;
    logic [3:0]  an_q,         an_d;
    logic [6:0]  seg_n_q,      seg_n_d;

    logic        boundary;
    logic        lit;
    logic [6:0]  digit_seg;

    // Raw segment pattern of the digit currently being scanned.
    always_comb begin
        digit_seg = 7'h00;
        case (digit_q)
            2'd0:    digit_seg = front_q[6:0];
            2'd1:    digit_seg = front_q[13:7];
            2'd2:    digit_seg = front_q[20:14];
            default: digit_seg = front_q[27:21];
        endcase
    end

    // Last ACTIVE cycle of digit 3 closes the frame.
    assign boundary = (state_q == ST_ACTIVE) && (digit_q == 2'd3) && (cnt_q == ACTIVE_LAST);

    // Lit while the current quarter of the window is within the brightness level.
    assign lit = (cnt_q[AW-1 -: 2] <= bright_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        digit_d      = digit_q;
        bright_d     = bright_q;
        shadow_d     = shadow_q;
        front_d      = front_q;
        pending_d    = pending_q;
        frame_tick_d = 1'b0;
        an_d         = 4'hF;
        seg_n_d      = 7'h7F;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d  = ST_ACTIVE;
                    cnt_d    = '0;
                    // Brightness is frozen for the whole digit window.
                    bright_d = bus.BRIGHT;
                end
            end
            default: begin
                if (cnt_q == ACTIVE_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                end
            end
        endcase

        if (bus.WR_EN) begin
            shadow_d  = bus.WR_DATA;
            pending_d = 1'b1;
        end

        if (boundary) begin
            frame_tick_d = 1'b1;
            if (bus.WR_EN) begin
                // A write landing exactly on the boundary goes straight to the
                // display; waiting a whole frame for it would be pointless.
                front_d   = bus.WR_DATA;
                pending_d = 1'b0;
            end else if (pending_q) begin
                front_d   = shadow_q;
                pending_d = 1'b0;
            end
        end

        if ((state_q == ST_ACTIVE) && lit) begin
            an_d    = ~(4'b0001 << digit_q);
            seg_n_d = ~digit_seg;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            bright_q     <= 2'd0;
            shadow_q     <= '0;
            front_q      <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            an_q         <= 4'hF;
            seg_n_q      <= 7'h7F;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            bright_q     <= bright_d;
            shadow_q     <= shadow_d;
            front_q      <= front_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_n_q      <= seg_n_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.SEG_N      = seg_n_q;
    assign bus.PENDING    = pending_q;
    assign bus.FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//  Scoreboard bench for seg_scan_ctrl with ACTIVE_CYCLES=16, BLANK_CYCLES=2
//  (18 cycles per digit, 72 per frame). The stimulus process queues the
//  lit pulses and frame ticks it expects; the monitor measures every lit
//  pulse (anode, length, preceding dark gap, segment value) and every tick
//  (interval, PENDING) at the falling edge and checks them against the queues.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic CLK;
    logic RESET;
    int   ecount = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    seg_scan_ctrl_if bus_if ();

    seg_scan_ctrl #(
        .ACTIVE_CYCLES (16),
        .BLANK_CYCLES  (2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         len;
        int         gap;
    } pulse_t;

    typedef struct {
        int   gap;
        logic pend;
    } tick_t;

    pulse_t pulse_q[$];
    tick_t  tick_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Rising edges since the last reset release.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, ecount, act, exp);
        end
    endtask

    // Returns 1 time unit after rising edge n.
    task automatic wait_edge(input int n);
        while (ecount < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_pulse(input logic [3:0] an, input logic [6:0] seg, input int len, input int gap);
        pulse_t p;
        p.an  = an;
        p.seg = seg;
        p.len = len;
        p.gap = gap;
        pulse_q.push_back(p);
    endtask

    task automatic push_tick(input int gap);
        tick_t t;
        t.gap  = gap;
        t.pend = 1'b0;
        tick_q.push_back(t);
    endtask

    // Full-brightness frame: four 16-cycle pulses, 2-cycle gaps after the first.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input int gap0, input int tick_gap);
        push_pulse(4'b1110, s0, 16, gap0);
        push_pulse(4'b1101, s1, 16, 2);
        push_pulse(4'b1011, s2, 16, 2);
        push_pulse(4'b0111, s3, 16, 2);
        push_tick(tick_gap);
    endtask

    task automatic write_frame(input logic [27:0] data);
        bus_if.WR_EN   = 1'b1;
        bus_if.WR_DATA = data;
    endtask

    // ---------------- monitor ----------------
    logic [3:0] run_val    = 4'hF;
    int         run_len    = 0;
    int         prev_gap   = 0;
    logic [6:0] seg_first  = 7'h7F;
    logic       seg_stable = 1'b1;
    int         tick_cnt   = 0;
    logic       tick_prev  = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                run_val   = 4'hF;
                run_len   = 0;
                prev_gap  = 0;
                tick_cnt  = 0;
                tick_prev = 1'b0;
            end else begin
                if (bus_if.AN == 4'hF)
                    chk("blank_seg", 32'(bus_if.SEG_N), 32'h7F);

                if (bus_if.AN != run_val) begin
                    if (run_val != 4'hF) begin
                        if (pulse_q.size() == 0) begin
                            chk("pulse_unexpected", 32'(run_val), 32'hF);
                        end else begin
                            pulse_t e;
                            e = pulse_q.pop_front();
                            chk("pulse_an",  32'(run_val), 32'(e.an));
                            chk("pulse_len", 32'(run_len), 32'(e.len));
                            chk("pulse_gap", 32'(prev_gap), 32'(e.gap));
                            chk("pulse_seg", 32'({seg_stable, seg_first}), 32'({1'b1, e.seg}));
                        end
                    end else begin
                        prev_gap = run_len;
                    end
                    run_val    = bus_if.AN;
                    run_len    = 1;
                    seg_first  = bus_if.SEG_N;
                    seg_stable = 1'b1;
                end else begin
                    run_len++;
                    if (bus_if.SEG_N != seg_first) seg_stable = 1'b0;
                end

                tick_cnt++;
                if (tick_prev)
                    chk("tick_width", 32'(bus_if.FRAME_TICK), 32'h0);
                if (bus_if.FRAME_TICK && !tick_prev) begin
                    if (tick_q.size() == 0) begin
                        chk("tick_unexpected", 32'(bus_if.FRAME_TICK), 32'h0);
                    end else begin
                        tick_t t;
                        t = tick_q.pop_front();
                        chk("tick_interval", 32'(tick_cnt), 32'(t.gap));
                        chk("tick_pending",  32'(bus_if.PENDING), 32'(t.pend));
                    end
                    tick_cnt = 0;
                end
                tick_prev = bus_if.FRAME_TICK;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        RESET          = 1'b1;
        bus_if.WR_EN   = 1'b0;
        bus_if.WR_DATA = 28'h0;
        bus_if.BRIGHT  = 2'd3;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_an",      32'(bus_if.AN), 32'hF);
        chk("reset_seg",     32'(bus_if.SEG_N), 32'h7F);
        chk("reset_pending", 32'(bus_if.PENDING), 32'h0);
        chk("reset_tick",    32'(bus_if.FRAME_TICK), 32'h0);
        RESET = 1'b0;

        // Short scan, then reset in the middle of digit 0's lit window.
        wait_edge(3);
        write_frame(28'hFFFFFFF);
        wait_edge(4);
        bus_if.WR_EN = 1'b0;
        wait_edge(8);
        chk("pre_an",      32'(bus_if.AN), 32'hE);
        chk("pre_pending", 32'(bus_if.PENDING), 32'h1);
        #2;
        RESET = 1'b1;
        #1;
        chk("midrst_an",      32'(bus_if.AN), 32'hF);
        chk("midrst_seg",     32'(bus_if.SEG_N), 32'h7F);
        chk("midrst_pending", 32'(bus_if.PENDING), 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Frame 0: blank front frame; first lit cycle 3 cycles after release.
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 3, 73);

        // Write during digit 1: held in shadow until the frame boundary.
        wait_edge(27);
        write_frame(28'h0FDFFFF);
        wait_edge(28);
        bus_if.WR_EN = 1'b0;
        chk("shadow_pending", 32'(bus_if.PENDING), 32'h1);
        push_frame(7'h00, 7'h00, 7'h08, 7'h78, 2, 72);
        wait_edge(74);
        chk("loaded_pending", 32'(bus_if.PENDING), 32'h0);

        // Write on the boundary cycle of frame 1, then another one cycle later.
        wait_edge(143);
        write_frame(28'h1234567);
        push_frame(7'h18, 7'h75, 7'h72, 7'h76, 2, 72);
        wait_edge(144);
        chk("bnd_pending", 32'(bus_if.PENDING), 32'h0);
        write_frame(28'hABCDEF0);
        push_frame(7'h0F, 7'h42, 7'h0C, 7'h2A, 2, 72);
        wait_edge(145);
        bus_if.WR_EN = 1'b0;
        chk("post_bnd_pending", 32'(bus_if.PENDING), 32'h1);
        wait_edge(215);
        chk("hold_pending", 32'(bus_if.PENDING), 32'h1);
        wait_edge(217);
        chk("late_loaded_pending", 32'(bus_if.PENDING), 32'h0);

        // Back-to-back writes: only the second is ever shown.
        wait_edge(229);
        write_frame(28'hFFFFFFF);
        wait_edge(230);
        write_frame(28'h0204081);
        wait_edge(231);
        bus_if.WR_EN = 1'b0;
        chk("b2b_pending", 32'(bus_if.PENDING), 32'h1);

        // Brightness: change in frame 3 digit 3 window (ignored there),
        // 25% on frame 4 digit 0, 75% from digit 1, back to 100% for digit 3.
        wait_edge(280);
        bus_if.BRIGHT = 2'd0;
        push_pulse(4'b1110, 7'h7E, 4, 2);
        push_pulse(4'b1101, 7'h7E, 12, 14);
        push_pulse(4'b1011, 7'h7E, 12, 6);
        push_pulse(4'b0111, 7'h7E, 16, 6);
        push_tick(72);
        push_frame(7'h7E, 7'h7E, 7'h7E, 7'h7E, 2, 72);
        wait_edge(289);
        chk("b2b_loaded_pending", 32'(bus_if.PENDING), 32'h0);
        wait_edge(295);
        bus_if.BRIGHT = 2'd2;
        wait_edge(330);
        bus_if.BRIGHT = 2'd3;

        wait_edge(440);
        chk("pulses_left", 32'(pulse_q.size()), 32'h0);
        chk("ticks_left",  32'(tick_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
